instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Front-end stage that feeds the multi-cycle control unit.
- Holds the program counter (PC) and, when the control unit raises fetch, issues a request/ready handshake to instruction memory.
- Latches the returned word into the instruction register and presents instruction and opcode to decode and control.
- Updates the PC (sequential or target) when the control unit signals end of instruction, and flags misaligned targets and memory timeouts.

Parameters:
WORDSIZE, 64, PC and address width
INSTRUCTION_SIZE, 32, instruction width
RESET_PC, 0, PC value after reset
TIMEOUT_CYCLES, 16, maximum cycles in REQ without imem_ready before error (must be >= 1)

Ports:
clk  in  1  system clock; all state changes on posedge
reset  in  1  asynchronous, active-high reset
fetch  in  1  fetch command from control unit; a rising edge starts one fetch
pc_update  in  1  one-cycle pulse at instruction completion; commit next PC
pc_sel  in  1  0: PC+4, 1: pc_target
pc_target  in  WORDSIZE  branch/jump target
imem_addr  out  WORDSIZE  instruction memory address
imem_req  out  1  memory request
imem_ready  in  1  memory data valid this cycle
imem_rdata  in  INSTRUCTION_SIZE  memory read data
instruction  out  INSTRUCTION_SIZE  instruction register
opcode  out  7  instruction[6:0]
pc  out  WORDSIZE  address of the current instruction
fetch_done  out  1  one-cycle pulse: instruction register updated
misaligned  out  1  one-cycle pulse: rejected target with pc_target[1:0] != 0
fetch_error  out  1  sticky memory timeout flag

Behaviour:
- Reset (async, any state): pc=RESET_PC; instruction=32'h00000013 (NOP); opcode=7'b0010011; imem_req=0; imem_addr=RESET_PC; fetch_done=0; misaligned=0; fetch_error=0; state=IDLE; timeout counter=0; fetch edge register=0.
- Fetch start: fetch_q registers fetch; start = fetch & ~fetch_q. A start outside IDLE is ignored and is not queued.
- IDLE: on start -> REQ. imem_req=0.
- REQ: imem_req=1, imem_addr=pc, both registered and held stable until the state is left.
  - Counter increments each cycle without imem_ready.
  - imem_ready high at a posedge: instruction<=imem_rdata, opcode<=imem_rdata[6:0] -> DONE.
  - Counter reaching TIMEOUT_CYCLES with imem_ready low -> ERROR.
  - imem_ready on the same edge the counter hits its limit: the data is taken, no error.
- DONE: fetch_done=1 for exactly one cycle; imem_req=0; -> IDLE.
- ERROR: imem_req=0; fetch_error=1 until reset; starts ignored; instruction keeps its last value.
- Latency: start at edge t gives imem_req high after t. With ready at the first REQ edge, fetch_done is high for the cycle after that edge. Minimum start-to-fetch_done latency is 2 cycles.
- PC update, accepted only in IDLE or DONE:
  - pc_sel=0: pc<=pc+4, wrapping modulo 2^WORDSIZE.
  - pc_sel=1 with pc_target[1:0]==0: pc<=pc_target.
  - pc_sel=1 with pc_target[1:0]!=0: pc unchanged; misaligned=1 for one cycle.
- pc_update during REQ or ERROR is dropped; no flag. Control guarantees it never does this.
- pc_update and start on the same edge in IDLE: the PC commits first. The request goes out with the new PC (imem_addr uses the next-PC value).
- instruction/opcode change only on an accepted imem_ready. They are stable from fetch_done until the next accepted response.

Decomposition:
- Shared package riscv_pkg:
  - opcode constants (R, I, I_load, S, B, J, J_I, U, U_PC, E);
  - NOP_INSTR=32'h00000013;
  - fetch state encoding (IDLE, REQ, DONE, ERROR) and control-unit state encoding.
- Sub-module pc_reg: PC register, PC+4 adder, target mux, alignment check. Outputs pc, next_pc and misaligned.
- The instruction_fetch_unit top level contains the FSM, timeout counter, fetch edge detect and instruction register.

Test Plan:
- Reset then fetch rise, imem_ready in first REQ cycle with rdata=32'h003100B3 -> imem_addr=0, imem_req for 1 cycle, instruction=32'h003100B3, opcode=7'b0110011, one fetch_done pulse.
- pc_update pc_sel=0 three times from RESET_PC=0, with fetches between -> imem_addr sequence 0, 4, 8, 12.
- pc_update pc_sel=1 pc_target=64'h100 -> next fetch at 0x100. pc_target=64'h102 -> misaligned pulse, pc stays 0x100.
- imem_ready delayed 5 cycles, TIMEOUT_CYCLES=16 -> imem_req held 6 cycles, imem_addr stable, fetch_done once.
- imem_ready never asserted -> fetch_error high after 16 REQ cycles, imem_req low; later fetch rises ignored until reset.
- Reset asserted mid-REQ; fetch held high across DONE -> all outputs return to reset values immediately, no fetch_done; a held-high fetch produces only one fetch.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the core front end and control unit.
//   - RV opcode constants decoded from instruction[6:0]
//   - NOP_INSTR: canonical NOP (addi x0, x0, 0), the instruction register reset value
//   - fetch_state_e: instruction fetch unit FSM states
//   - cu_state_e: multi-cycle control unit FSM states
//   - is_word_aligned(): instruction address alignment check
package riscv_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_I_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_S      = 7'b0100011;
  localparam logic [6:0] OPC_B      = 7'b1100011;
  localparam logic [6:0] OPC_J      = 7'b1101111;
  localparam logic [6:0] OPC_J_I    = 7'b1100111;
  localparam logic [6:0] OPC_U      = 7'b0110111;
  localparam logic [6:0] OPC_U_PC   = 7'b0010111;
  localparam logic [6:0] OPC_E      = 7'b1110011;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_DONE,
    FETCH_ERROR
  } fetch_state_e;

  typedef enum logic [2:0] {
    CU_FETCH,
    CU_DECODE,
    CU_EXECUTE,
    CU_MEMORY,
    CU_WRITEBACK
  } cu_state_e;

  function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_pc_reg.sv
// Program counter register with sequential/target next-PC selection.
//   clk, reset  : clock, asynchronous active-high reset
//   update_en   : commit next PC this edge (already qualified by fetch state)
//   pc_sel      : 0 = PC+4, 1 = pc_target
//   pc_target   : branch/jump target
//   pc          : current PC
//   next_pc     : PC value after this edge (equals pc when no update)
//   misaligned  : one-cycle pulse after a rejected misaligned target
module pc_reg
  import riscv_pkg::*;
#(
  parameter int unsigned           WORDSIZE = 64,
  parameter logic [WORDSIZE-1:0]   RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                update_en,
  input  logic                pc_sel,
  input  logic [WORDSIZE-1:0] pc_target,
  output logic [WORDSIZE-1:0] pc,
  output logic [WORDSIZE-1:0] next_pc,
  output logic                misaligned
);

  logic [WORDSIZE-1:0] pc_q, pc_d;
  logic                misaligned_q, misaligned_d;

  always_comb begin
    pc_d         = pc_q;
    misaligned_d = 1'b0;
    if (update_en) begin
      if (!pc_sel) begin
        pc_d = pc_q + WORDSIZE'(4);
      end else if (is_word_aligned(pc_target[1:0])) begin
        pc_d = pc_target;
      end else begin
        misaligned_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign pc         = pc_q;
  assign next_pc    = pc_d;
  assign misaligned = misaligned_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end for the multi-cycle control unit.
//   fetch (rising edge) starts one request/ready transaction on imem_*;
//   the returned word is latched into instruction/opcode and fetch_done
//   pulses once. pc_update commits PC+4 or pc_target (via pc_reg) while
//   idle or done. A request unanswered for TIMEOUT_CYCLES cycles sets the
//   sticky fetch_error and parks the unit until reset.
module instruction_fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned         WORDSIZE         = 64,
  parameter int unsigned         INSTRUCTION_SIZE = 32,
  parameter logic [WORDSIZE-1:0] RESET_PC         = '0,
  parameter int unsigned         TIMEOUT_CYCLES   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        fetch,
  input  logic                        pc_update,
  input  logic                        pc_sel,
  input  logic [WORDSIZE-1:0]         pc_target,
  output logic [WORDSIZE-1:0]         imem_addr,
  output logic                        imem_req,
  input  logic                        imem_ready,
  input  logic [INSTRUCTION_SIZE-1:0] imem_rdata,
  output logic [INSTRUCTION_SIZE-1:0] instruction,
  output logic [6:0]                  opcode,
  output logic [WORDSIZE-1:0]         pc,
  output logic                        fetch_done,
  output logic                        misaligned,
  output logic                        fetch_error
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  fetch_state_e                state_q, state_d;
  logic                        fetch_q;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        req_q, req_d;
  logic [WORDSIZE-1:0]         addr_q, addr_d;
  logic [INSTRUCTION_SIZE-1:0] instr_q, instr_d;
  logic                        done_q, done_d;
  logic                        err_q, err_d;
  logic                        start;
  logic                        pc_update_en;
  logic [WORDSIZE-1:0]         next_pc;

  assign start        = fetch & ~fetch_q;
  assign pc_update_en = pc_update & ((state_q == FETCH_IDLE) | (state_q == FETCH_DONE));

  pc_reg #(
    .WORDSIZE (WORDSIZE),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .reset      (reset),
    .update_en  (pc_update_en),
    .pc_sel     (pc_sel),
    .pc_target  (pc_target),
    .pc         (pc),
    .next_pc    (next_pc),
    .misaligned (misaligned)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      FETCH_IDLE: begin
        if (start) begin
          state_d = FETCH_REQ;
          req_d   = 1'b1;
          // next_pc so a PC commit on the same edge is fetched, not the stale PC
          addr_d  = next_pc;
          cnt_d   = '0;
        end
      end
      FETCH_REQ: begin
        // ready wins over a timeout on the same edge
        if (imem_ready) begin
          instr_d = imem_rdata;
          req_d   = 1'b0;
          done_d  = 1'b1;
          state_d = FETCH_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            req_d   = 1'b0;
            err_d   = 1'b1;
            state_d = FETCH_ERROR;
          end
        end
      end
      FETCH_DONE:  state_d = FETCH_IDLE;
      FETCH_ERROR: state_d = FETCH_ERROR;
      default:     state_d = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH_IDLE;
      fetch_q <= 1'b0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      instr_q <= INSTRUCTION_SIZE'(NOP_INSTR);
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fetch_q <= fetch;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instruction = instr_q;
  assign opcode      = instr_q[6:0];
  assign fetch_done  = done_q;
  assign fetch_error = err_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch, pc_update, pc_sel;
  logic [63:0] pc_target;
  logic [63:0] imem_addr;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [6:0]  opcode;
  logic [63:0] pc;
  logic        fetch_done, misaligned, fetch_error;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .WORDSIZE         (64),
    .INSTRUCTION_SIZE (32),
    .RESET_PC         (64'd0),
    .TIMEOUT_CYCLES   (T)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch       (fetch),
    .pc_update   (pc_update),
    .pc_sel      (pc_sel),
    .pc_target   (pc_target),
    .imem_addr   (imem_addr),
    .imem_req    (imem_req),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .opcode      (opcode),
    .pc          (pc),
    .fetch_done  (fetch_done),
    .misaligned  (misaligned),
    .fetch_error (fetch_error)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a transaction is "outstanding" (m_req), "just finished"
  // (m_done) or "dead" (m_err); otherwise the unit is free.
  logic [63:0] m_pc, m_addr;
  logic [31:0] m_instr;
  bit          m_req, m_done, m_mis, m_err, m_fprev;
  int          m_wait;

  always @(posedge clk or posedge reset) begin : model
    logic [63:0] pc_n, addr_n;
    logic [31:0] instr_n;
    bit          req_n, done_n, mis_n, err_n;
    int          wait_n;
    if (reset) begin
      m_pc <= 64'd0; m_addr <= 64'd0; m_instr <= 32'h00000013;
      m_req <= 1'b0; m_done <= 1'b0; m_mis <= 1'b0; m_err <= 1'b0;
      m_fprev <= 1'b0; m_wait <= 0;
    end else begin
      pc_n = m_pc; addr_n = m_addr; instr_n = m_instr;
      req_n = m_req; err_n = m_err; wait_n = m_wait;
      done_n = 1'b0; mis_n = 1'b0;
      if (m_err) begin
        // dead until reset
      end else if (m_req) begin
        if (imem_ready) begin
          instr_n = imem_rdata; req_n = 1'b0; done_n = 1'b1;
        end else begin
          wait_n = m_wait + 1;
          if (wait_n == T) begin req_n = 1'b0; err_n = 1'b1; end
        end
      end else begin
        if (pc_update) begin
          if (!pc_sel) pc_n = m_pc + 64'd4;
          else if (pc_target[1:0] == 2'b00) pc_n = pc_target;
          else mis_n = 1'b1;
        end
        if (fetch && !m_fprev && !m_done) begin
          req_n = 1'b1; addr_n = pc_n; wait_n = 0;
        end
      end
      m_fprev <= fetch; m_pc <= pc_n; m_addr <= addr_n; m_instr <= instr_n;
      m_req <= req_n; m_done <= done_n; m_mis <= mis_n; m_err <= err_n; m_wait <= wait_n;
    end
  end

  always @(posedge clk) begin : compare
    #1;
    check("pc", pc, m_pc);
    check("imem_req", 64'(imem_req), 64'(m_req));
    check("imem_addr", imem_addr, m_addr);
    check("instruction", 64'(instruction), 64'(m_instr));
    check("opcode", 64'(opcode), 64'(m_instr[6:0]));
    check("fetch_done", 64'(fetch_done), 64'(m_done));
    check("misaligned", 64'(misaligned), 64'(m_mis));
    check("fetch_error", 64'(fetch_error), 64'(m_err));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_update(input logic sel, input logic [63:0] tgt);
    pc_update = 1'b1; pc_sel = sel; pc_target = tgt;
    tick();
    pc_update = 1'b0;
  endtask

  // Raise fetch, answer after 'delay' REQ cycles; report REQ cycles, done pulses,
  // the request address and whether it stayed stable.
  task automatic do_fetch(input int delay, input logic [31:0] data,
                          output int reqc, output int donec,
                          output logic [63:0] a, output logic stable);
    reqc = 0; donec = 0; stable = 1'b1;
    fetch = 1'b1;
    tick();
    pc_update = 1'b0;
    a = imem_addr;
    while (imem_req && reqc < 40) begin
      if (imem_addr !== a) stable = 1'b0;
      imem_ready = (reqc == delay);
      imem_rdata = data;
      reqc++;
      tick();
      imem_ready = 1'b0;
      if (fetch_done) donec++;
    end
    fetch = 1'b0;
    repeat (3) begin
      tick();
      if (fetch_done) donec++;
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    int          rc, dc, n_req, n_done;
    logic [63:0] a;
    logic        st;
    reset = 1'b0; fetch = 1'b0; pc_update = 1'b0; pc_sel = 1'b0;
    pc_target = 64'd0; imem_ready = 1'b0; imem_rdata = 32'd0;
    #2 reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_pc", pc, 64'd0);
    check("rst_instr", 64'(instruction), 64'h13);
    check("rst_opcode", 64'(opcode), 64'(7'b0010011));
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_addr", imem_addr, 64'd0);
    check("rst_flags", {61'd0, fetch_done, misaligned, fetch_error}, 64'd0);

    // first fetch, ready in the first REQ cycle
    do_fetch(0, 32'h003100B3, rc, dc, a, st);
    check("f1_addr", a, 64'd0);
    check("f1_reqc", 64'(rc), 64'd1);
    check("f1_done", 64'(dc), 64'd1);
    check("f1_instr", 64'(instruction), 64'h003100B3);
    check("f1_opcode", 64'(opcode), 64'(7'b0110011));

    // sequential PC updates
    for (int i = 1; i <= 3; i++) begin
      pulse_update(1'b0, 64'd0);
      do_fetch(0, $urandom, rc, dc, a, st);
      check("seq_addr", a, 64'(4 * i));
    end

    // aligned target, then misaligned target
    pulse_update(1'b1, 64'h100);
    do_fetch(0, $urandom, rc, dc, a, st);
    check("tgt_addr", a, 64'h100);
    pulse_update(1'b1, 64'h102);
    check("mis_pulse", 64'(misaligned), 64'd1);
    check("mis_pc", pc, 64'h100);
    tick();
    check("mis_clear", 64'(misaligned), 64'd0);

    // delayed ready
    do_fetch(5, 32'h00A00093, rc, dc, a, st);
    check("dly_reqc", 64'(rc), 64'd6);
    check("dly_done", 64'(dc), 64'd1);
    check("dly_stable", 64'(st), 64'd1);
    check("dly_addr", a, 64'h100);

    // PC commit and start on the same edge: request uses the new PC
    pc_update = 1'b1; pc_sel = 1'b0;
    do_fetch(1, 32'h00000073, rc, dc, a, st);
    check("same_edge_addr", a, 64'h104);
    check("same_edge_opcode", 64'(opcode), 64'(7'b1110011));

    // PC+4 wraps
    pulse_update(1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    pulse_update(1'b0, 64'd0);
    check("wrap_pc", pc, 64'd0);

    // fetch held high, memory always ready: exactly one transaction
    fetch = 1'b1; imem_ready = 1'b1; n_req = 0; n_done = 0;
    repeat (10) begin
      tick();
      if (imem_req) n_req++;
      if (fetch_done) n_done++;
    end
    fetch = 1'b0; imem_ready = 1'b0;
    tick();
    check("held_req", 64'(n_req), 64'd1);
    check("held_done", 64'(n_done), 64'd1);

    // reset in the middle of a request
    fetch = 1'b1;
    tick(); tick();
    check("mid_req", 64'(imem_req), 64'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_req", 64'(imem_req), 64'd0);
    check("mid_rst_instr", 64'(instruction), 64'h13);
    check("mid_rst_pc", pc, 64'd0);
    imem_ready = 1'b1;
    tick();
    check("mid_rst_done", 64'(fetch_done), 64'd0);
    reset = 1'b0; fetch = 1'b0; imem_ready = 1'b0;
    tick();

    // timeout
    do_fetch(1000, 32'd0, rc, dc, a, st);
    check("to_reqc", 64'(rc), 64'(T));
    check("to_err", 64'(fetch_error), 64'd1);
    check("to_req", 64'(imem_req), 64'd0);
    check("to_instr", 64'(instruction), 64'h13);
    do_fetch(0, 32'h12345678, rc, dc, a, st);
    check("to_ignored_req", 64'(rc), 64'd0);
    check("to_ignored_done", 64'(dc), 64'd0);
    check("to_sticky", 64'(fetch_error), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("to_cleared", 64'(fetch_error), 64'd0);

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) fetch = ~fetch;
      pc_update  = ($urandom_range(0, 5) == 0);
      pc_sel     = 1'($urandom_range(0, 1));
      pc_target  = {$urandom, $urandom};
      if ($urandom_range(0, 2) != 0) pc_target[1:0] = 2'b00;
      imem_ready = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      reset      = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
